// File: rtl/motor_input_conditioner_if.sv
// Signal bundle between the raw operator/limit inputs and the conditioned
// controls handed to the motor FSM.
interface motor_input_conditioner_if;
  // No valid/ready handshake: raw inputs are asynchronous levels, activate is
  // a one-cycle pulse, up_limit/dn_limit/limit_fault are registered levels.
  logic btn_raw;
  logic up_sw_raw;
  logic dn_sw_raw;
  logic activate;
  logic up_limit;
  logic dn_limit;
  logic limit_fault;

  modport master (
    output btn_raw, up_sw_raw, dn_sw_raw,
    input  activate, up_limit, dn_limit, limit_fault
  );

  modport slave (
    input  btn_raw, up_sw_raw, dn_sw_raw,
    output activate, up_limit, dn_limit, limit_fault
  );
endinterface

// File: rtl/motor_input_conditioner.sv
// Synchronizes and debounces the push-button and both end-of-travel switches,
// producing an activate pulse, clean limit levels and a both-limits fault flag.
module motor_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  motor_input_conditioner_if.slave   bus
);
  localparam int NCH    = 3;
  localparam int CH_BTN = 0;
  localparam int CH_UP  = 1;
  localparam int CH_DN  = 2;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]         raw;
  logic [NCH-1:0]         sync_out;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [CW-1:0]          cnt_q  [NCH];
  logic [NCH-1:0]         lvl_q;
  logic                   btn_d_q;
  logic                   activate_q;
  logic                   fault_q;
  logic                   fault_next;

  assign raw = {bus.dn_sw_raw, bus.up_sw_raw, bus.btn_raw};

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < NCH; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Each channel: a plain flop chain, then a counter that only reaches the
  // accept point after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      lvl_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_out[i] != lvl_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            lvl_q[i] <= sync_out[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign fault_next = lvl_q[CH_UP] & lvl_q[CH_DN];

  // A press accepted under fault is dropped for good: btn_d still follows
  // the level, so clearing the fault later cannot produce a late edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_d_q    <= 1'b0;
      activate_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      btn_d_q    <= lvl_q[CH_BTN];
      activate_q <= lvl_q[CH_BTN] & ~btn_d_q & ~fault_next;
      fault_q    <= fault_next;
    end
  end

  assign bus.activate    = activate_q;
  assign bus.up_limit    = lvl_q[CH_UP];
  assign bus.dn_limit    = lvl_q[CH_DN];
  assign bus.limit_fault = fault_q;
endmodule

// File: tb/tb_motor_input_conditioner.sv
// Directed bench for motor_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// stimulus queues expected output-change events, a monitor checks them.
module tb_motor_input_conditioner;
  localparam int W = 36;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  logic [W-1:0] exp_q[$];
  logic [3:0]   prev_vec;
  logic [3:0]   cur_vec;
  logic [W-1:0] e;

  motor_input_conditioner_if bus();

  motor_input_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic expect_at(input int c, input logic [3:0] v);
    exp_q.push_back({c[31:0], v});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_vec(input string name, input logic [3:0] want);
    logic [3:0] got;
    got = {bus.activate, bus.up_limit, bus.dn_limit, bus.limit_fault};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got {act,up,dn,flt}=%b required %b", name, got, want);
    end
  endtask

  // scoreboard monitor: every change of the output vector is one event
  initial prev_vec = 4'b0000;
  always @(negedge clk) begin
    cur_vec = {bus.activate, bus.up_limit, bus.dn_limit, bus.limit_fault};
    if (cur_vec !== prev_vec) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: cyc=%0d got=%b required no change", cyc, cur_vec);
      end else begin
        e = exp_q.pop_front();
        if (e !== {cyc[31:0], cur_vec}) begin
          bad++;
          $display("FAIL output_event: got cyc=%0d vec=%b required cyc=%0d vec=%b",
                   cyc, cur_vec, e[35:4], e[3:0]);
        end
      end
      prev_vec = cur_vec;
    end
  end

  int b;
  int pat[6];

  initial begin
    total = 0;
    bad   = 0;
    pat   = '{1, 0, 1, 1, 0, 1};
    rst = 1'b1;
    bus.btn_raw   = 1'b0;
    bus.up_sw_raw = 1'b0;
    bus.dn_sw_raw = 1'b0;
    idle(3);
    check_vec("reset_state", 4'b0000);
    rst = 1'b0;
    idle(5);

    // 1: clean press and hold
    @(negedge clk); b = cyc; bus.btn_raw = 1'b1;
    expect_at(b + 7, 4'b1000);
    expect_at(b + 8, 4'b0000);
    idle(58);
    @(negedge clk); bus.btn_raw = 1'b0;
    idle(12);

    // 2: bouncy press
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) b = cyc;
      bus.btn_raw = pat[i][0];
    end
    expect_at(b + 12, 4'b1000);
    expect_at(b + 13, 4'b0000);
    idle(20);
    @(negedge clk); bus.btn_raw = 1'b0;
    idle(12);

    // 3: short up glitch rejected, then qualified rise and fall
    @(negedge clk); bus.up_sw_raw = 1'b1;
    idle(3);
    bus.up_sw_raw = 1'b0;
    idle(8);
    @(negedge clk); b = cyc; bus.up_sw_raw = 1'b1;
    expect_at(b + 6, 4'b0100);
    idle(12);
    @(negedge clk); b = cyc; bus.up_sw_raw = 1'b0;
    expect_at(b + 6, 4'b0000);
    idle(12);

    // 4: both limits -> fault, press masked, no deferred pulse
    @(negedge clk); b = cyc; bus.dn_sw_raw = 1'b1;
    expect_at(b + 6, 4'b0010);
    idle(12);
    @(negedge clk); b = cyc; bus.up_sw_raw = 1'b1;
    expect_at(b + 6, 4'b0110);
    expect_at(b + 7, 4'b0111);
    idle(12);
    @(negedge clk); bus.btn_raw = 1'b1;
    idle(14);
    check_vec("fault_masks_press", 4'b0111);
    @(negedge clk); b = cyc; bus.dn_sw_raw = 1'b0;
    expect_at(b + 6, 4'b0101);
    expect_at(b + 7, 4'b0100);
    idle(16);
    check_vec("no_deferred_pulse", 4'b0100);
    @(negedge clk); b = cyc; bus.btn_raw = 1'b0; bus.up_sw_raw = 1'b0;
    expect_at(b + 6, 4'b0000);
    idle(12);

    // 5: reset mid-qualification with up limit already accepted
    @(negedge clk); b = cyc; bus.up_sw_raw = 1'b1;
    expect_at(b + 6, 4'b0100);
    idle(12);
    @(negedge clk); b = cyc; bus.btn_raw = 1'b1;
    expect_at(b + 4, 4'b0000);
    expect_at(b + 12, 4'b0100);
    expect_at(b + 13, 4'b1100);
    expect_at(b + 14, 4'b0100);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_vec("async_reset_clears", 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(20);
    @(negedge clk); b = cyc; bus.btn_raw = 1'b0; bus.up_sw_raw = 1'b0;
    expect_at(b + 6, 4'b0000);
    idle(12);

    // 6: all three inputs rise together
    @(negedge clk); b = cyc;
    bus.btn_raw = 1'b1; bus.up_sw_raw = 1'b1; bus.dn_sw_raw = 1'b1;
    expect_at(b + 6, 4'b0110);
    expect_at(b + 7, 4'b0111);
    idle(14);
    @(negedge clk); b = cyc;
    bus.btn_raw = 1'b0; bus.up_sw_raw = 1'b0; bus.dn_sw_raw = 1'b0;
    expect_at(b + 6, 4'b0001);
    expect_at(b + 7, 4'b0000);
    idle(14);

    // final report
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got no change, required cyc=%0d vec=%b", e[35:4], e[3:0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
